// File: rtl/dtree_control_mc.sv
// dtree_control_mc: multi-channel decision-tree walk sequencer feeding the MAC datapath strobes.
// Optional run-time node writes with DTREE_CFG_WRITE_EN; otherwise nodes come from the NODE_INIT image.
//
// state   | meaning
// S_IDLE  | ready for a spike or a node write
// S_FETCH | synchronous node-memory read
// S_EVAL  | FEATURES strobe cycles for the current node
// S_WAIT  | waiting for the datapath sign decision
// S_DONE  | result held on out_* until out_ready
module dtree_control_mc #(
  parameter int FEATURES        = 3,
  parameter int COEFF_BIT_DEPTH = 4,
  parameter int BIAS_BIT_DEPTH  = 10,
  parameter int MAX_DEPTH       = 3,
  parameter int CHANNEL_COUNT   = 16,
  parameter logic [CHANNEL_COUNT*((1 << MAX_DEPTH) - 1)*
                   (2 + FEATURES + (FEATURES - 1)*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH)-1:0]
                  NODE_INIT     = '0,
  localparam int NPC    = (1 << MAX_DEPTH) - 1,
  localparam int CH_W   = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int NODE_W = 2 + FEATURES + (FEATURES - 1)*COEFF_BIT_DEPTH + BIAS_BIT_DEPTH,
  localparam int A_W    = $clog2(CHANNEL_COUNT*NPC),
  localparam int L_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CH_W-1:0]            in_channel,
  input  logic                       dir_valid,
  input  logic                       child_direction,
  output logic                       node_valid,
  output logic                       load_bias,
  output logic                       add,
  output logic                       mult,
  output logic                       is_one,
  output logic                       is_zero,
  output logic [COEFF_BIT_DEPTH-1:0] coeff,
  output logic [BIAS_BIT_DEPTH-1:0]  bias,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_channel,
  output logic [L_W-1:0]             out_level,
  output logic [MAX_DEPTH-1:0]       out_path
`ifdef DTREE_CFG_WRITE_EN
  ,
  input  logic                       cfg_we,
  input  logic [A_W-1:0]             cfg_addr,
  input  logic [NODE_W-1:0]          cfg_data
`endif
);

  localparam int DEPTH    = CHANNEL_COUNT*NPC;
  localparam int NI_W     = (NPC > 1) ? $clog2(NPC) : 1;
  localparam int K_W      = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int NC       = FEATURES - 1;
  localparam int COEF_LSB = BIAS_BIT_DEPTH;
  localparam int ONE_LSB  = COEF_LSB + NC*COEFF_BIT_DEPTH;
  localparam int FLAG_LSB = ONE_LSB + FEATURES;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [NI_W-1:0]      node_q, node_d;
  logic [L_W-1:0]       level_q, level_d;
  logic [MAX_DEPTH-1:0] path_q, path_d;
  logic [K_W-1:0]       cnt_q, cnt_d;
  logic [K_W-1:0]       j_q, j_d;
  logic [NODE_W-1:0]    word_q, word_d;

  logic [NODE_W-1:0]          rd_word;
  logic [A_W-1:0]             rd_addr;
  logic                       cfg_we_eff;
  logic [1:0]                 flags;
  logic [FEATURES-1:0]        one_pos;
  logic [BIAS_BIT_DEPTH-1:0]  bias_f;
  logic [COEFF_BIT_DEPTH-1:0] coeff_sel;
  logic                       one_bit;
  logic                       coeff_nz;
  logic                       child_ok;

  assign rd_addr = A_W'(int'(ch_q)*NPC + int'(node_q));

`ifdef DTREE_CFG_WRITE_EN
  logic [NODE_W-1:0] mem [DEPTH];

  assign cfg_we_eff = cfg_we;
  assign rd_word    = mem[rd_addr];

  // Writes land only in an idle, out-of-reset cycle; memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (reset && state_q == S_IDLE && cfg_we && int'(cfg_addr) < DEPTH)
      mem[cfg_addr] <= cfg_data;
  end
`else
  assign cfg_we_eff = 1'b0;
  assign rd_word    = NODE_INIT[int'(rd_addr)*NODE_W +: NODE_W];
`endif

  assign flags   = word_q[FLAG_LSB +: 2];
  assign one_pos = word_q[ONE_LSB +: FEATURES];
  assign bias_f  = word_q[0 +: BIAS_BIT_DEPTH];

  // c0 sits in the most significant coefficient slot; cnt_q counts down so it indexes one_pos directly.
  always_comb begin
    coeff_sel = '0;
    for (int i = 0; i < NC; i++) begin
      if (j_q == K_W'(i))
        coeff_sel = word_q[COEF_LSB + (NC - 1 - i)*COEFF_BIT_DEPTH +: COEFF_BIT_DEPTH];
    end
    one_bit = 1'b0;
    for (int i = 0; i < FEATURES; i++) begin
      if (cnt_q == K_W'(i))
        one_bit = one_pos[i];
    end
  end

  assign coeff_nz = (coeff_sel != '0);
  assign child_ok = child_direction ? flags[0] : flags[1];

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    node_d     = node_q;
    level_d    = level_q;
    path_d     = path_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    word_d     = word_q;
    in_ready   = 1'b0;
    node_valid = 1'b0;
    load_bias  = 1'b0;
    add        = 1'b0;
    mult       = 1'b0;
    is_one     = 1'b0;
    is_zero    = 1'b0;
    coeff      = '0;
    bias       = '0;
    out_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = reset & ~cfg_we_eff;
        if (in_valid && !cfg_we_eff) begin
          ch_d    = in_channel;
          node_d  = '0;
          level_d = '0;
          path_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        word_d  = rd_word;
        cnt_d   = K_W'(FEATURES - 1);
        j_d     = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        node_valid = 1'b1;
        load_bias  = (cnt_q == K_W'(FEATURES - 1));
        is_one     = one_bit;
        coeff      = one_bit ? '0 : coeff_sel;
        is_zero    = ~one_bit & ~coeff_nz;
        mult       = ~one_bit & coeff_nz;
        add        = one_bit | coeff_nz;
        bias       = bias_f;
        if (cnt_q == '0) begin
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - K_W'(1);
          if (!one_bit)
            j_d = j_q + K_W'(1);
        end
      end
      S_WAIT: begin
        bias = bias_f;
        if (dir_valid) begin
          for (int i = 0; i < MAX_DEPTH; i++) begin
            if (level_q == L_W'(i))
              path_d[i] = child_direction;
          end
          level_d = level_q + L_W'(1);
          // The depth limit uses the pre-increment level, so a full walk records MAX_DEPTH decisions.
          if (child_ok && (int'(level_q) + 1 < MAX_DEPTH)) begin
            node_d  = NI_W'(2*int'(node_q) + 1 + int'(child_direction));
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      node_q  <= '0;
      level_q <= '0;
      path_q  <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      node_q  <= node_d;
      level_q <= level_d;
      path_q  <= path_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      word_q  <= word_d;
    end
  end

  assign out_channel = ch_q;
  assign out_level   = level_q;
  assign out_path    = path_q;

endmodule
